// File: rtl/fp_exc_to_ieee_stream.sv
// fp_exc_to_ieee_stream
// Converts a 34-bit internal floating-point word (2-bit exception class plus
// sign/exponent/fraction) into IEEE-754 binary32. The stream has two
// valid/ready stages: S1 holds the decoded word and S2 is the output register.
// Three saturating counters track the NaN, overflow and underflow flags of
// words that leave the block.
module fp_exc_to_ieee_stream #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [33:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [2:0]       out_flags,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_nan,
  output logic [CNT_W-1:0] cnt_ovf,
  output logic [CNT_W-1:0] cnt_unf
);

  localparam logic [1:0] EXC_ZERO = 2'b00;
  localparam logic [1:0] EXC_NORM = 2'b01;
  localparam logic [1:0] EXC_INF  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  // Result is {flags[2:0], ieee[31:0]}. Flags are ordered {nan, overflow, underflow}.
  function automatic logic [34:0] convert(input logic [33:0] w);
    logic       sgn;
    logic [7:0] exp;
    sgn = w[31];
    exp = w[30:23];
    case (w[33:32])
      EXC_ZERO: convert = {3'b000, sgn, 8'h00, 23'h000000};
      EXC_NORM: begin
        if (exp == 8'h00) begin
          // Denormal range is flushed to a signed zero.
          convert = {3'b001, sgn, 8'h00, 23'h000000};
        end else if (exp == 8'hFF) begin
          // Exponent out of range saturates to a signed infinity.
          convert = {3'b010, sgn, 8'hFF, 23'h000000};
        end else begin
          convert = {3'b000, w[31:0]};
        end
      end
      EXC_INF:  convert = {3'b000, sgn, 8'hFF, 23'h000000};
      EXC_NAN:  convert = {3'b100, 32'h7FC00000};
      default:  convert = {3'b000, 32'h00000000};
    endcase
  endfunction

  // Saturating increment with clear priority.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                 input logic hit,
                                                 input logic clr);
    if (clr) begin
      cnt_next = {CNT_W{1'b0}};
    end else if (hit && (c != {CNT_W{1'b1}})) begin
      cnt_next = c + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_next = c;
    end
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [31:0]       s1_data_q,  s1_data_d;
  logic [2:0]        s1_flags_q, s1_flags_d;
  logic              s2_valid_q, s2_valid_d;
  logic [31:0]       s2_data_q,  s2_data_d;
  logic [2:0]        s2_flags_q, s2_flags_d;
  logic [CNT_W-1:0]  cnt_nan_q,  cnt_nan_d;
  logic [CNT_W-1:0]  cnt_ovf_q,  cnt_ovf_d;
  logic [CNT_W-1:0]  cnt_unf_q,  cnt_unf_d;
  logic [34:0]       conv_s;
  logic              s1_accept_s;
  logic              s2_load_s;
  logic              out_fire_s;

  // Handshake decode: S1 may take a new word whenever it is empty or is moving into S2.
  always_comb begin
    conv_s      = convert(in_data);
    in_ready    = !s1_valid_q || !s2_valid_q || out_ready;
    s1_accept_s = in_valid && in_ready;
    s2_load_s   = s1_valid_q && (!s2_valid_q || out_ready);
    out_fire_s  = s2_valid_q && out_ready;
  end

  // Next-state for both pipeline stages; data registers hold unless loaded.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_flags_d = s1_flags_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_flags_d = s2_flags_q;
    if (s1_accept_s) begin
      s1_valid_d = 1'b1;
      s1_data_d  = conv_s[31:0];
      s1_flags_d = conv_s[34:32];
    end else if (s2_load_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s2_load_s) begin
      s2_valid_d = 1'b1;
      s2_data_d  = s1_data_q;
      s2_flags_d = s1_flags_q;
    end else if (out_fire_s) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Event counters count flags of words accepted by the downstream side.
  always_comb begin
    cnt_nan_d = cnt_next(cnt_nan_q, out_fire_s && s2_flags_q[2], cnt_clr);
    cnt_ovf_d = cnt_next(cnt_ovf_q, out_fire_s && s2_flags_q[1], cnt_clr);
    cnt_unf_d = cnt_next(cnt_unf_q, out_fire_s && s2_flags_q[0], cnt_clr);
  end

  // State registers; reset empties the pipeline and clears the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= 32'h00000000;
      s1_flags_q <= 3'b000;
      s2_valid_q <= 1'b0;
      s2_data_q  <= 32'h00000000;
      s2_flags_q <= 3'b000;
      cnt_nan_q  <= {CNT_W{1'b0}};
      cnt_ovf_q  <= {CNT_W{1'b0}};
      cnt_unf_q  <= {CNT_W{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_flags_q <= s1_flags_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_flags_q <= s2_flags_d;
      cnt_nan_q  <= cnt_nan_d;
      cnt_ovf_q  <= cnt_ovf_d;
      cnt_unf_q  <= cnt_unf_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_flags = s2_flags_q;
  assign cnt_nan   = cnt_nan_q;
  assign cnt_ovf   = cnt_ovf_q;
  assign cnt_unf   = cnt_unf_q;

endmodule

// File: tb/tb_fp_exc_to_ieee_stream.sv
// Directed bench for fp_exc_to_ieee_stream. Two instances share the stimulus:
// dut uses the default counter width, dut2 uses CNT_W=2 to reach saturation.
module tb_fp_exc_to_ieee_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [33:0] in_data;
  logic        out_ready;
  logic        cnt_clr;

  logic        in_ready,  in_ready2;
  logic        out_valid, out_valid2;
  logic [31:0] out_data,  out_data2;
  logic [2:0]  out_flags, out_flags2;
  logic [15:0] cnt_nan, cnt_ovf, cnt_unf;
  logic [1:0]  cnt_nan2, cnt_ovf2, cnt_unf2;

  int n_chk;
  int n_fail;

  fp_exc_to_ieee_stream dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags), .cnt_clr(cnt_clr),
    .cnt_nan(cnt_nan), .cnt_ovf(cnt_ovf), .cnt_unf(cnt_unf)
  );

  fp_exc_to_ieee_stream #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_flags(out_flags2), .cnt_clr(cnt_clr),
    .cnt_nan(cnt_nan2), .cnt_ovf(cnt_ovf2), .cnt_unf(cnt_unf2)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [33:0] mk(input logic [1:0] exc, input logic sgn,
                                     input logic [7:0] exp, input logic [22:0] frac);
    mk = {exc, sgn, exp, frac};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 34'h0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  out_data, 32'h0);
    chk("rst_out_flags", 32'(out_flags), 32'h0);
    chk("rst_cnt_nan",   32'(cnt_nan), 32'h0);
    chk("rst_cnt_ovf",   32'(cnt_ovf), 32'h0);
    chk("rst_cnt_unf",   32'(cnt_unf), 32'h0);
    chk("rst_in_ready",  32'(in_ready), 32'h1);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);

    // Three-word stream at full rate: 1.0, -0, -inf.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = mk(2'b01, 1'b0, 8'h7F, 23'h0);
    tick();
    chk("lat_not_yet", 32'(out_valid), 32'h0);
    in_data = mk(2'b00, 1'b1, 8'h55, 23'h123);
    tick();
    chk("s_one_valid", 32'(out_valid), 32'h1);
    chk("s_one_data",  out_data, 32'h3F800000);
    chk("s_one_flags", 32'(out_flags), 32'h0);
    in_data = mk(2'b10, 1'b1, 8'h12, 23'h7);
    tick();
    chk("s_negzero_data",  out_data, 32'h80000000);
    chk("s_negzero_flags", 32'(out_flags), 32'h0);
    in_valid = 1'b0;
    tick();
    chk("s_neginf_valid", 32'(out_valid), 32'h1);
    chk("s_neginf_data",  out_data, 32'hFF800000);
    chk("s_neginf_flags", 32'(out_flags), 32'h0);
    tick();
    chk("s_drained", 32'(out_valid), 32'h0);
    chk("s_cnt_nan0", 32'(cnt_nan), 32'h0);

    // NaN with sign and payload -> canonical quiet NaN.
    in_valid = 1'b1;
    in_data  = mk(2'b11, 1'b1, 8'hAB, 23'h1234);
    tick();
    in_valid = 1'b0;
    tick();
    chk("nan_data",  out_data, 32'h7FC00000);
    chk("nan_flags", 32'(out_flags), 32'h4);
    tick();
    chk("nan_cnt",  32'(cnt_nan), 32'h1);
    chk("nan_cnt2", 32'(cnt_nan2), 32'h1);

    // Underflow flush and overflow saturation.
    in_valid = 1'b1;
    in_data  = mk(2'b01, 1'b1, 8'h00, 23'h55);
    tick();
    in_data = mk(2'b01, 1'b0, 8'hFF, 23'h3);
    tick();
    chk("unf_data",  out_data, 32'h80000000);
    chk("unf_flags", 32'(out_flags), 32'h1);
    in_valid = 1'b0;
    tick();
    chk("ovf_data",  out_data, 32'h7F800000);
    chk("ovf_flags", 32'(out_flags), 32'h2);
    chk("unf_cnt",   32'(cnt_unf), 32'h1);
    tick();
    chk("ovf_cnt",    32'(cnt_ovf), 32'h1);
    chk("unf_cnt_b",  32'(cnt_unf), 32'h1);
    chk("ovf_drained", 32'(out_valid), 32'h0);

    // Backpressure: capacity of exactly two words, stable output, ordered release.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = mk(2'b01, 1'b0, 8'h80, 23'h1);
    #1;
    chk("bp_ready_empty", 32'(in_ready), 32'h1);
    tick();
    in_data = mk(2'b01, 1'b1, 8'h81, 23'h2);
    #1;
    chk("bp_ready_one", 32'(in_ready), 32'h1);
    tick();
    chk("bp_w1_data", out_data, 32'h40000001);
    in_data = mk(2'b01, 1'b0, 8'h01, 23'h3);
    #1;
    chk("bp_ready_full", 32'(in_ready), 32'h0);
    tick();
    tick();
    chk("bp_hold_valid", 32'(out_valid), 32'h1);
    chk("bp_hold_data",  out_data, 32'h40000001);
    chk("bp_hold_ready", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_drain", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("bp_w2_data", out_data, 32'hC0800002);
    tick();
    chk("bp_w3_data", out_data, 32'h00800003);
    tick();
    chk("bp_empty", 32'(out_valid), 32'h0);

    // Four more NaN words: narrow counter saturates at 3, wide one reaches 5.
    in_valid = 1'b1;
    in_data  = mk(2'b11, 1'b0, 8'h00, 23'h1);
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("sat_cnt2", 32'(cnt_nan2), 32'h3);
    chk("sat_cnt",  32'(cnt_nan), 32'h5);

    // Clear coinciding with a NaN leaving the block: clear wins.
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("clr_pre_valid", 32'(out_valid), 32'h1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_cnt_nan",  32'(cnt_nan), 32'h0);
    chk("clr_cnt_nan2", 32'(cnt_nan2), 32'h0);
    chk("clr_cnt_ovf",  32'(cnt_ovf), 32'h0);
    chk("clr_cnt_unf",  32'(cnt_unf), 32'h0);

    // Mid-operation reset with two words buffered.
    in_valid = 1'b1;
    in_data  = mk(2'b11, 1'b0, 8'h00, 23'h0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mr_cnt_pre", 32'(cnt_nan), 32'h1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = mk(2'b01, 1'b0, 8'h10, 23'h1);
    tick();
    tick();
    in_valid = 1'b0;
    chk("mr_buffered", 32'(in_ready), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'h0);
    chk("mr_out_data",  out_data, 32'h0);
    chk("mr_cnt_nan",   32'(cnt_nan), 32'h0);
    chk("mr_in_ready",  32'(in_ready), 32'h1);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_no_stale", 32'(out_valid), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_exc_to_ieee_stream.md
FP_EXC_TO_IEEE_STREAM -- requirements
Module: fp_exc_to_ieee_stream

Interface
REQ-001: Parameter CNT_W, default 16, width of each saturating event counter.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst_n  input  1  reset, asynchronous, active-low.
REQ-004: in_valid  input  1  in_data holds a word to convert.
REQ-005: in_ready  output  1  block accepts in_data this cycle.
REQ-006: in_data  input  34  internal FP word: [33:32] exception (00 zero, 01 normal, 10 inf, 11 NaN), [31] sign, [30:23] exponent, [22:0] fraction.
REQ-007: out_valid  output  1  out_data/out_flags hold a converted word.
REQ-008: out_ready  input  1  downstream accepts the output word this cycle.
REQ-009: out_data  output  32  IEEE-754 binary32: [31] sign, [30:23] exponent, [22:0] fraction.
REQ-010: out_flags  output  3  per-word flags {nan, overflow, underflow}.
REQ-011: cnt_clr  input  1  synchronous clear of all event counters.
REQ-012: cnt_nan, cnt_ovf, cnt_unf  output  CNT_W each  saturating event counts.

Function
REQ-013: Two-stage pipeline S1 (decode) and S2 (output register), each with its own valid bit; transfer occurs when valid and ready are both 1 in the same cycle.
REQ-014: in_ready = !s1_valid | !s2_valid | out_ready (S1 advances into S2 when S2 is empty or draining); in_ready is combinational.
REQ-015: Latency: accepted word appears on out_data exactly 2 cycles after acceptance when out_ready stays 1; throughput 1 word/cycle sustained.
REQ-016: With out_ready=0, out_valid/out_data/out_flags stay stable until accepted; no word is dropped or duplicated; capacity 2 words.
REQ-017: Conversion, exc=00: out_data = {sign, 8'h00, 23'h0}; flags 000.
REQ-018: exc=01, exponent 1..254: out_data = {sign, exponent, fraction}; flags 000.
REQ-019: exc=01, exponent 0: flush to {sign, 8'h00, 23'h0}; underflow flag 1.
REQ-020: exc=01, exponent 255: {sign, 8'hFF, 23'h0}; overflow flag 1.
REQ-021: exc=10: {sign, 8'hFF, 23'h0}; flags 000.
REQ-022: exc=11: canonical quiet NaN 32'h7FC00000 regardless of sign/fraction; nan flag 1.
REQ-023: Conversion is computed combinationally from in_data and registered into S1; S2 is a pure register copy of S1.
REQ-024: Each counter increments by 1 when a word carrying the corresponding flag is accepted at the output (out_valid & out_ready).
REQ-025: Counters saturate at 2^CNT_W-1 and hold.
REQ-026: cnt_clr=1 zeroes all counters next edge; takes priority over a simultaneous increment.
REQ-027: out_data/out_flags hold their value when out_valid=0 (no requirement on content after the first word).

Reset
REQ-028: rst_n=0 asynchronously clears s1_valid, s2_valid, out_valid=0, out_data=0, out_flags=0, all counters=0.
REQ-029: in_ready=1 during and immediately after reset (pipeline empty).
REQ-030: Reset asserted mid-operation discards all in-flight words; no output word is produced for them after release.

Verification
REQ-031: Stream {01,0,8'h7F,0}, {00,1,...}, {10,1,...} with out_ready=1 -> outputs 32'h3F800000, 32'h80000000, 32'hFF800000 on cycles 2,3,4 after first accept, flags 000.
REQ-032: in_data exc=11, sign=1, fraction 23'h1234 -> out_data 32'h7FC00000, out_flags 100, cnt_nan=1.
REQ-033: exc=01 exp=0 sign=1 -> 32'h80000000 flags 001; exc=01 exp=255 sign=0 -> 32'h7F800000 flags 010; cnt_unf=1, cnt_ovf=1.
REQ-034: out_ready=0 with in_valid=1 continuously -> exactly 2 words accepted, in_ready drops to 0, out_data stable; raise out_ready -> the 2 words emerge in order, no loss.
REQ-035: CNT_W=2, four NaN words accepted -> cnt_nan=3 (saturated); cnt_clr with a concurrent NaN accept -> cnt_nan=0.
REQ-036: Assert rst_n=0 with 2 words buffered -> out_valid=0 and counters 0 immediately; after release, no stale word appears.
